track_cache_ctrl: RTL and testbench
===================================

// Module: track_cache_ctrl
// PURPOSE
//  Parametrised single-track disk cache between the SD block interface and a floppy/disk controller.
//  Holds one whole track of SECTORS x 512 B in a dual-port buffer and loads it on a track change.
//  Writes back dirty sectors before a reload, on remount, or optionally after write inactivity.
//  One instance per drive. Adds a per-sector dirty mask, write-protect, range check and error flag.
// PARAMETERS
//  SECTORS      13      sectors per track (1..16); buffer depth = SECTORS*512 bytes
//  TRK_W        6       width of track number
//  NUM_TRACKS   35      valid tracks 0..NUM_TRACKS-1
//  ADDR_W       13      fd_addr width; must satisfy 2^ADDR_W >= SECTORS*512
//  IDLE_CYCLES  1000000 idle-flush delay in clk cycles (used only with TRACK_IDLE_FLUSH_EN)
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high
//  active       in   1       drive selected; gates fd_we
//  track        in   TRK_W   requested track
//  img_mounted  in   1       1-cycle pulse: new image mounted
//  img_size     in   64      image size in bytes, sampled on img_mounted
//  img_readonly in   1       sampled on img_mounted; 1 = write-protected
//  sd_lba       out  32      block address of the current SD request
//  sd_rd/sd_wr  out  1       SD block read/write request, level
//  sd_ack       in   1       SD handshake; high while a block is transferring
//  sd_buff_addr in   9       byte index within the block
//  sd_buff_wr   in   1       SD->buffer byte strobe
//  sd_buff_dout in   8       SD->buffer data
//  sd_buff_din  out  8       buffer->SD data; 1-cycle read latency
//  fd_addr      in   ADDR_W  controller byte address within the track
//  fd_we        in   1       controller write strobe
//  fd_din       in   8       controller write data
//  fd_dout      out  8       controller read data; 1-cycle read latency
//  busy         out  1       transfer in progress; controller must stall
//  dirty        out  1       OR of the per-sector dirty mask
//  err          out  1       sticky: track out of range or image too small; cleared by mount/reset
// BEHAVIOUR
//  Reset values: sd_rd=0, sd_wr=0, busy=0, err=0, sd_lba=0, dirty mask=0, state=IDLE, cur_track=invalid.
//  Reset is honoured in any state. An active SD request is dropped. The next IDLE cycle sees a track mismatch and reloads.
//  Geometry:
//   - LBA = SECTORS*track + sec, computed in 32 bits with no truncation.
//   - Buffer address = {sec, sd_buff_addr}; fd_addr indexes the same array.
//  Write path:
//   - fd_we & active & ~busy & ~ro writes the buffer and sets dirty[fd_addr/512].
//   - fd_we is ignored while busy, while ro, or when fd_addr >= SECTORS*512.
//  FSM:
//   - IDLE -> SCAN when track!=cur_track, remount is pending, or (feature) the idle timer expired.
//   - SCAN: If img_size==0, go to IDLE with no SD traffic. Otherwise, if dirty is set, go to WB.
//     If dirty is clear and this is a track change or remount, go to RD; for a flush only, go to IDLE.
//   - WB: For each sec with dirty[sec] in ascending order: assert sd_wr with sd_lba = LBA(cur_track, sec).
//     On the rising edge of sd_ack, drop sd_wr. On the falling edge, clear dirty[sec].
//     When the mask is empty, go to RD (track change/remount) or IDLE (flush).
//   - RD: If track >= NUM_TRACKS or the LBA end exceeds img_size/512, set err and go to IDLE with cur_track := track (no retry).
//     Otherwise read sec 0..SECTORS-1. On each rising edge of sd_ack, drop sd_rd. On each falling edge, advance sec.
//     Re-raise sd_rd the next cycle until all sectors are done, then set cur_track := track and go to IDLE.
//  busy=1 in every state except IDLE; it rises the cycle after the trigger.
//  A track change during WB or RD is latched by the IDLE compare after completion, not mid-transfer.
//  img_mounted in any state: capture size and ro, and clear err. The dirty mask of the old image is discarded, not written.
//   - If not in IDLE, the pulse is held pending.
//  At most one SD request is outstanding; sd_rd and sd_wr are never high together.
// CONFIGURATION
//  TRACK_IDLE_FLUSH_EN defined:
//   - A counter resets on every accepted fd_we and counts while dirty && IDLE.
//   - At IDLE_CYCLES it triggers a flush (WB then IDLE, no reload).
//  Not defined: no counter exists. A dirty track is written only on track change.
// TESTING
//  Mount 143360 B, track 0->3: 13 reads at LBA 39..51, busy high throughout, fd_dout returns loaded bytes.
//  Write 0x5A at fd_addr 0x0210 on track 3, then set track=4: exactly one sd_wr at LBA 40, then reads at LBA 52..64.
//  track=40 (NUM_TRACKS=35): err=1, no sd_rd/sd_wr, busy returns to 0 within 3 cycles.
//  img_readonly=1, fd_we: dirty stays 0. Track change produces reads only.
//  Assert reset mid-read at sector 5: sd_rd=0 and busy=0 next cycle. After reset, the same track reloads from sector 0.
//  With TRACK_IDLE_FLUSH_EN, IDLE_CYCLES=100: write, wait 100 cycles -> one sd_wr, then dirty=0, with no reload.

Source files
------------

// File: rtl/track_cache_ctrl.sv
// track_cache_ctrl: single-track disk cache between the SD block interface and a
// floppy/disk controller. One whole track (SECTORS x 512 B) lives in a dual-port
// buffer. It is reloaded on a track change or remount. Dirty sectors are written
// back before a reload. Write-protect, an fd_addr range check and a sticky error
// flag are included.
// Optional feature: define TRACK_IDLE_FLUSH_EN to flush dirty sectors after
// IDLE_CYCLES clocks with no accepted controller write.
module track_cache_ctrl #(
    parameter int SECTORS     = 13,
    parameter int TRK_W       = 6,
    parameter int NUM_TRACKS  = 35,
    parameter int ADDR_W      = 13,
    parameter int IDLE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic [TRK_W-1:0]  track,
    input  logic              img_mounted,
    input  logic [63:0]       img_size,
    input  logic              img_readonly,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_dout,
    output logic [7:0]        sd_buff_din,
    input  logic [ADDR_W-1:0] fd_addr,
    input  logic              fd_we,
    input  logic [7:0]        fd_din,
    output logic [7:0]        fd_dout,
    output logic              busy,
    output logic              dirty,
    output logic              err
);
    localparam int SEC_W     = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam int MEM_AW    = SEC_W + 9;
    localparam int TRK_BYTES = SECTORS * 512;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_WB, ST_RD} state_t;

    state_t             state_q, state_d;
    logic [TRK_W-1:0]   cur_track_q, cur_track_d;
    logic               cur_valid_q, cur_valid_d;
    logic [TRK_W-1:0]   tgt_q, tgt_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               act_q, act_d;
    logic               reload_q, reload_d;
    logic               sd_rd_q, sd_rd_d;
    logic               sd_wr_q, sd_wr_d;
    logic [31:0]        sd_lba_q, sd_lba_d;
    logic [SECTORS-1:0] dirty_q, dirty_d;
    logic               err_q, err_d;
    logic               pend_q, pend_d;
    logic               ack_q;
    logic [63:0]        size_q;
    logic               ro_q;
    logic [7:0]         mem_q [0:TRK_BYTES-1];
    logic [7:0]         sd_buff_din_q, fd_dout_q;

    logic               fd_ok, ack_rise, ack_fall, range_bad, flush_trig;
    logic [SEC_W-1:0]   fd_sec, first_dirty;
    logic [MEM_AW-1:0]  sd_mem_a, fd_mem_a;
    logic [31:0]        tgt_end;

    function automatic logic [31:0] lba_of(input logic [TRK_W-1:0] t, input logic [SEC_W-1:0] s);
        return 32'(SECTORS) * 32'(t) + 32'(s);
    endfunction

    assign fd_ok     = fd_we & active & (state_q == ST_IDLE) & ~ro_q &
                       ({1'b0, fd_addr} < (ADDR_W+1)'(TRK_BYTES));
    assign fd_sec    = fd_addr[MEM_AW-1:9];
    assign fd_mem_a  = fd_addr[MEM_AW-1:0];
    assign sd_mem_a  = {sec_q, sd_buff_addr};
    assign ack_rise  = sd_ack & ~ack_q;
    assign ack_fall  = ~sd_ack & ack_q;
    assign tgt_end   = 32'(SECTORS) * (32'(tgt_q) + 32'd1);
    assign range_bad = (32'(tgt_q) >= 32'(NUM_TRACKS)) || ({32'b0, tgt_end} > (size_q >> 9));

`ifdef TRACK_IDLE_FLUSH_EN
    logic [31:0] idle_cnt_q;

    // Idle timer: restarts on each accepted write, advances while dirty in IDLE
    always_ff @(posedge clk) begin
        if (reset || fd_ok)
            idle_cnt_q <= '0;
        else if (state_q == ST_IDLE && |dirty_q && idle_cnt_q != 32'(IDLE_CYCLES))
            idle_cnt_q <= idle_cnt_q + 32'd1;
    end

    assign flush_trig = (idle_cnt_q == 32'(IDLE_CYCLES)) && |dirty_q;
`else
    // No idle timer in this build; IDLE_CYCLES has no effect and this never fires
    assign flush_trig = (IDLE_CYCLES < 0);
`endif

    // Lowest-numbered dirty sector (loop runs downward so the lowest wins)
    always_comb begin
        first_dirty = '0;
        for (int unsigned i = SECTORS; i > 0; i--)
            if (dirty_q[i-1]) first_dirty = SEC_W'(i - 1);
    end

    // Next-state logic for the scan / write-back / read sequencer
    always_comb begin
        state_d     = state_q;
        cur_track_d = cur_track_q;
        cur_valid_d = cur_valid_q;
        tgt_d       = tgt_q;
        sec_d       = sec_q;
        act_d       = act_q;
        reload_d    = reload_q;
        sd_rd_d     = sd_rd_q;
        sd_wr_d     = sd_wr_q;
        sd_lba_d    = sd_lba_q;
        dirty_d     = dirty_q;
        err_d       = err_q;
        pend_d      = pend_q;
        if (fd_ok) dirty_d[fd_sec] = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (track != cur_track_q || !cur_valid_q || pend_q || flush_trig) begin
                    state_d  = ST_SCAN;
                    tgt_d    = track;
                    reload_d = (track != cur_track_q) || !cur_valid_q || pend_q;
                    pend_d   = 1'b0;
                end
            end
            ST_SCAN: begin
                sec_d = '0;
                act_d = 1'b0;
                if (size_q == 64'd0) begin
                    cur_track_d = tgt_q;
                    cur_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (|dirty_q) begin
                    state_d = ST_WB;
                end else begin
                    state_d = reload_q ? ST_RD : ST_IDLE;
                end
            end
            ST_WB: begin
                if (act_q) begin
                    if (ack_rise) sd_wr_d = 1'b0;
                    if (ack_fall) begin
                        dirty_d[sec_q] = 1'b0;
                        act_d          = 1'b0;
                    end
                end else if (|dirty_q) begin
                    sec_d    = first_dirty;
                    sd_lba_d = lba_of(cur_track_q, first_dirty);
                    sd_wr_d  = 1'b1;
                    act_d    = 1'b1;
                end else begin
                    sec_d   = '0;
                    state_d = reload_q ? ST_RD : ST_IDLE;
                end
            end
            ST_RD: begin
                if (act_q) begin
                    if (ack_rise) sd_rd_d = 1'b0;
                    if (ack_fall) begin
                        act_d = 1'b0;
                        if (sec_q == SEC_W'(SECTORS - 1)) begin
                            cur_track_d = tgt_q;
                            cur_valid_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            sec_d = sec_q + 1'b1;
                        end
                    end
                end else if (range_bad) begin
                    err_d       = 1'b1;
                    cur_track_d = tgt_q;
                    cur_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    sd_lba_d = lba_of(tgt_q, sec_q);
                    sd_rd_d  = 1'b1;
                    act_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A mount discards the old image's dirty data and defers the reload
        // until the sequencer is back in IDLE.
        if (img_mounted) begin
            err_d   = 1'b0;
            dirty_d = '0;
            pend_d  = 1'b1;
        end
    end

    // Sequencer state registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_track_q <= '0;
            cur_valid_q <= 1'b0;
            tgt_q       <= '0;
            sec_q       <= '0;
            act_q       <= 1'b0;
            reload_q    <= 1'b0;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
            sd_lba_q    <= '0;
            dirty_q     <= '0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_track_q <= cur_track_d;
            cur_valid_q <= cur_valid_d;
            tgt_q       <= tgt_d;
            sec_q       <= sec_d;
            act_q       <= act_d;
            reload_q    <= reload_d;
            sd_rd_q     <= sd_rd_d;
            sd_wr_q     <= sd_wr_d;
            sd_lba_q    <= sd_lba_d;
            dirty_q     <= dirty_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            ack_q       <= sd_ack;
        end
    end

    // Image attributes survive reset so the current image reloads afterwards
    always_ff @(posedge clk) begin
        if (img_mounted) begin
            size_q <= img_size;
            ro_q   <= img_readonly;
        end
    end

    // Track buffer: SD port writes only while reading a track, controller port only in IDLE
    always_ff @(posedge clk) begin
        if (state_q == ST_RD && sd_ack && sd_buff_wr)
            mem_q[sd_mem_a] <= sd_buff_dout;
        if (fd_ok)
            mem_q[fd_mem_a] <= fd_din;
        sd_buff_din_q <= mem_q[sd_mem_a];
        fd_dout_q     <= mem_q[fd_mem_a];
    end

    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_buff_din = sd_buff_din_q;
    assign fd_dout     = fd_dout_q;
    assign busy        = (state_q != ST_IDLE);
    assign dirty       = |dirty_q;
    assign err         = err_q;

endmodule

// File: tb/tb_track_cache_ctrl.sv
// Directed bench for track_cache_ctrl with a behavioural SD block responder.
module tb_track_cache_ctrl;
    localparam int SECTORS    = 13;
    localparam int TRK_W      = 6;
    localparam int NUM_TRACKS = 35;
    localparam int ADDR_W     = 13;

    logic              clk = 1'b0;
    logic              reset, active, img_mounted, img_readonly;
    logic [TRK_W-1:0]  track;
    logic [63:0]       img_size;
    logic [31:0]       sd_lba;
    logic              sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout, sd_buff_din;
    logic [ADDR_W-1:0] fd_addr;
    logic              fd_we;
    logic [7:0]        fd_din, fd_dout;
    logic              busy, dirty, err;

    always #5 clk = ~clk;

    track_cache_ctrl #(
        .SECTORS(SECTORS), .TRK_W(TRK_W), .NUM_TRACKS(NUM_TRACKS),
        .ADDR_W(ADDR_W), .IDLE_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .active(active), .track(track),
        .img_mounted(img_mounted), .img_size(img_size), .img_readonly(img_readonly),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
        .fd_addr(fd_addr), .fd_we(fd_we), .fd_din(fd_din), .fd_dout(fd_dout),
        .busy(busy), .dirty(dirty), .err(err)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned rd_log[$];
    int unsigned wr_log[$];
    int unsigned overlap = 0;
    logic [7:0]  wdata [512];
    int          m_phase = 0;
    int          m_cnt   = 0;
    int unsigned m_lba   = 0;
    logic        m_wr    = 1'b0;
    int          cyc;

    // Byte stored on the virtual disk at (lba, offset)
    function automatic logic [7:0] pat(input int unsigned lba, input int unsigned i);
        return 8'((lba * 29) + i + ((i >> 8) * 71));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait for busy to rise (within rise_bound), then for it to fall; cyc = ticks used
    task automatic run_to_idle(input string tag, input int rise_bound, output int cyc_o);
        bit seen = 1'b0;
        cyc_o = 0;
        for (int n = 0; n < rise_bound && !seen; n++) begin
            tick();
            cyc_o++;
            if (busy) seen = 1'b1;
        end
        check({tag, "_busy_rise"}, 64'(seen), 64'd1);
        for (int k = 0; k < 9000 && busy; k++) begin
            tick();
            cyc_o++;
        end
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reads(input string tag, input int unsigned first);
        check({tag, "_rd_count"}, 64'(rd_log.size()), 64'(SECTORS));
        for (int i = 0; i < SECTORS; i++)
            check({tag, "_rd_lba"}, 64'(rd_log[i]), 64'(first + i));
    endtask

    // SD responder: 512-byte blocks, ack raised at request, one byte per cycle
    always @(negedge clk) begin
        if (reset) begin
            m_phase    = 0;
            sd_ack     = 1'b0;
            sd_buff_wr = 1'b0;
        end else if (m_phase == 0) begin
            if (sd_rd || sd_wr) begin
                m_wr  = sd_wr;
                m_lba = sd_lba;
                if (sd_wr) wr_log.push_back(sd_lba);
                else       rd_log.push_back(sd_lba);
                sd_ack       = 1'b1;
                sd_buff_addr = 9'd0;
                sd_buff_wr   = !m_wr;
                sd_buff_dout = pat(m_lba, 0);
                m_cnt        = 1;
                m_phase      = 1;
            end
        end else begin
            if (m_wr) wdata[m_cnt-1] = sd_buff_din;
            if (m_cnt < 512) begin
                sd_buff_addr = 9'(m_cnt);
                sd_buff_dout = pat(m_lba, m_cnt);
                m_cnt++;
            end else begin
                sd_ack     = 1'b0;
                sd_buff_wr = 1'b0;
                m_phase    = 0;
            end
        end
    end

    always @(posedge clk) if (sd_rd && sd_wr) overlap++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; active = 1'b1; track = '0; img_mounted = 1'b0;
        img_size = 64'd143360; img_readonly = 1'b0;
        sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0;
        fd_addr = '0; fd_we = 1'b0; fd_din = '0;
        repeat (2) tick();
        img_mounted = 1'b1; tick(); img_mounted = 1'b0; tick();
        check("rst_sd_rd", 64'(sd_rd), 64'd0);
        check("rst_sd_wr", 64'(sd_wr), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_err",   64'(err),   64'd0);
        check("rst_lba",   64'(sd_lba), 64'd0);
        check("rst_dirty", 64'(dirty), 64'd0);
        reset = 1'b0;
        run_to_idle("load0", 5, cyc);
        check_reads("load0", 0);

        // Track 0 -> 3: blocks 39..51
        rd_log.delete(); wr_log.delete();
        track = 6'd3;
        tick();
        check("t3_busy", 64'(busy), 64'd1);
        run_to_idle("t3", 5, cyc);
        check_reads("t3", 39);
        check("t3_wr_count", 64'(wr_log.size()), 64'd0);
        fd_addr = 13'h0210; tick(); tick();
        check("t3_dout_210", 64'(fd_dout), 64'(pat(40, 16)));
        fd_addr = 13'd6655; tick(); tick();
        check("t3_dout_last", 64'(fd_dout), 64'(pat(51, 511)));

        // Writes that must be ignored: drive inactive, address past the track
        active = 1'b0; fd_addr = 13'h0020; fd_din = 8'h11; fd_we = 1'b1; tick();
        fd_we = 1'b0; active = 1'b1; tick();
        check("inactive_dirty", 64'(dirty), 64'd0);
        fd_addr = 13'd6656; fd_we = 1'b1; tick(); fd_we = 1'b0; tick();
        check("range_dirty", 64'(dirty), 64'd0);

        // Write 0x5A at 0x210, then track 4: one write-back at block 40
        fd_addr = 13'h0210; fd_din = 8'h5A; fd_we = 1'b1; tick(); fd_we = 1'b0; tick();
        check("wr_dirty", 64'(dirty), 64'd1);
        check("wr_readback", 64'(fd_dout), 64'h5A);
        rd_log.delete(); wr_log.delete();
        track = 6'd4;
        run_to_idle("t4", 5, cyc);
        check("t4_wr_count", 64'(wr_log.size()), 64'd1);
        check("t4_wr_lba", 64'(wr_log[0]), 64'd40);
        check("t4_wb_byte", 64'(wdata[16]), 64'h5A);
        check("t4_wb_next", 64'(wdata[17]), 64'(pat(40, 17)));
        check_reads("t4", 52);
        check("t4_dirty", 64'(dirty), 64'd0);

        // Track 40 is out of range
        rd_log.delete(); wr_log.delete();
        track = 6'd40;
        run_to_idle("t40", 5, cyc);
        check("t40_err", 64'(err), 64'd1);
        check("t40_latency_le3", 64'(cyc <= 3), 64'd1);
        check("t40_rd_count", 64'(rd_log.size()), 64'd0);
        check("t40_wr_count", 64'(wr_log.size()), 64'd0);
        track = 6'd4;
        run_to_idle("back4", 5, cyc);
        check("err_sticky", 64'(err), 64'd1);

        // Remount write-protected: err clears, track reloads
        rd_log.delete();
        img_readonly = 1'b1; img_mounted = 1'b1; tick(); img_mounted = 1'b0;
        check("mount_err_clr", 64'(err), 64'd0);
        run_to_idle("remount", 5, cyc);
        check_reads("remount", 52);
        fd_addr = 13'h0210; fd_din = 8'h77; fd_we = 1'b1; tick(); fd_we = 1'b0; tick();
        check("ro_dirty", 64'(dirty), 64'd0);
        check("ro_data", 64'(fd_dout), 64'(pat(53, 16)));
        rd_log.delete(); wr_log.delete();
        track = 6'd5;
        run_to_idle("ro_t5", 5, cyc);
        check("ro_wr_count", 64'(wr_log.size()), 64'd0);
        check_reads("ro_t5", 65);

        // Reset in the middle of sector 5 of a track-6 load
        rd_log.delete();
        track = 6'd6;
        for (int k = 0; k < 8000 && rd_log.size() < 6; k++) tick();
        check("mid_reach_sec5", 64'(rd_log.size() >= 6), 64'd1);
        repeat (20) tick();
        reset = 1'b1; tick();
        check("mid_rst_sd_rd", 64'(sd_rd), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        rd_log.delete();
        tick(); reset = 1'b0;
        run_to_idle("reload6", 5, cyc);
        check_reads("reload6", 78);

`ifdef TRACK_IDLE_FLUSH_EN
        rd_log.delete();
        img_readonly = 1'b0; img_mounted = 1'b1; tick(); img_mounted = 1'b0;
        run_to_idle("rw_mount", 5, cyc);
        rd_log.delete(); wr_log.delete();
        fd_addr = 13'h0210; fd_din = 8'h3C; fd_we = 1'b1; tick(); fd_we = 1'b0;
        check("flush_dirty_set", 64'(dirty), 64'd1);
        run_to_idle("flush", 300, cyc);
        check("flush_wr_count", 64'(wr_log.size()), 64'd1);
        check("flush_wr_lba", 64'(wr_log[0]), 64'd79);
        check("flush_rd_count", 64'(rd_log.size()), 64'd0);
        check("flush_dirty_clr", 64'(dirty), 64'd0);
`endif

        check("rd_wr_overlap", 64'(overlap), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
